hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control for a 5-stage core with a multi-cycle execute unit.
//   Forwarding: ForwardAE/ForwardBE pick the operand source for execute.
//     00 = register file, 01 = ResultW, 10 = ALUResultM.
//   Load-use:   StallF/StallD hold fetch/decode while a load in execute feeds decode.
//   Branch:     FlushD/FlushE drop the wrong-path instructions on a taken PCSrcE.
//   Multi-cycle: StallE holds execute for MC_LATENCY cycles, FlushM feeds bubbles into memory.
//     McDoneE marks the final execute cycle.
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   Rs1D, Rs2D                  decode source registers
//   Rs1E, Rs2E, RdE             execute sources and destination
//   RdM, RdW                    memory / writeback destinations
//   RegWriteM, RegWriteW        destination-write enables
//   ResultSrcE0                 the instruction in execute is a load
//   PCSrcE                      taken branch/jump resolved in execute
//   MultiCycleE                 the instruction in execute is a multi-cycle op
//   ForwardAE, ForwardBE        operand selects
//   StallF, StallD, StallE      pipeline-register holds
//   FlushD, FlushE, FlushM      pipeline-register clears
//   McDoneE                     last execute cycle of a multi-cycle op
module hazard_unit #(
  parameter int unsigned word_width = 32,
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       MultiCycleE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       McDoneE
);

  localparam int unsigned CntW = $clog2(MC_LATENCY) + 1;

  // Elaboration-time sanity checks on the parameters.
  if (MC_LATENCY < 2 || MC_LATENCY > 32) begin : g_bad_latency
    $error("hazard_unit: MC_LATENCY must be in 2..32");
  end
  if (word_width < 1) begin : g_bad_width
    $error("hazard_unit: word_width must be at least 1");
  end

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic              w_mc_stall;
  logic              w_mc_done;
  logic              w_lw_stall;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The IDLE cycle that accepts the op counts as the first execute cycle, so BUSY
  // runs MC_LATENCY-1 more cycles: cnt counts down from MC_LATENCY-2 to 0.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_mc_stall   = 1'b0;
    w_mc_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (MultiCycleE) begin
          w_mc_stall   = 1'b1;
          w_state_next = BUSY;
          w_cnt_next   = CntW'(MC_LATENCY - 2);
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_mc_stall = 1'b1;
          w_cnt_next = r_cnt - CntW'(1);
        end else begin
          w_mc_done    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Memory stage wins over writeback when both hold the register.
  always_comb begin
    w_fwd_a = 2'b00;
    if (RegWriteM && (RdM == Rs1E) && (Rs1E != 5'd0)) begin
      w_fwd_a = 2'b10;
    end else if (RegWriteW && (RdW == Rs1E) && (Rs1E != 5'd0)) begin
      w_fwd_a = 2'b01;
    end
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (RegWriteM && (RdM == Rs2E) && (Rs2E != 5'd0)) begin
      w_fwd_b = 2'b10;
    end else if (RegWriteW && (RdW == Rs2E) && (Rs2E != 5'd0)) begin
      w_fwd_b = 2'b01;
    end
  end

  assign w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // During reset the pipeline is held in a flushed, non-stalled condition.
  always_comb begin
    ForwardAE = w_fwd_a;
    ForwardBE = w_fwd_b;
    StallF    = w_lw_stall | w_mc_stall;
    StallD    = w_lw_stall | w_mc_stall;
    StallE    = w_mc_stall;
    FlushM    = w_mc_stall;
    FlushD    = PCSrcE;
    // A held execute stage must not be flushed, even by a load-use hazard.
    FlushE    = (w_lw_stall | PCSrcE) & ~w_mc_stall;
    McDoneE   = w_mc_done;
    if (reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      McDoneE   = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McDoneE;

  always #5 clk = ~clk;

  hazard_unit #(.word_width(32), .MC_LATENCY(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE0(ResultSrcE0),
    .PCSrcE     (PCSrcE),
    .MultiCycleE(MultiCycleE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .McDoneE    (McDoneE)
  );

  // Output vector: {fa[1:0], fb[1:0], sf, sd, se, fd, fe, fm, done}
  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   done_cyc[$];

  function automatic logic [10:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic done);
    return {fa, fb, sf, sd, se, fd, fe, fm, done};
  endfunction

  function automatic logic [10:0] obs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McDoneE};
  endfunction

  // Push the expectation for the current inputs, compare on the falling edge, then
  // advance to just after the next rising edge.
  task automatic step(input string tag, input logic [10:0] e);
    exp_t x;
    exp_t y;
    logic [10:0] o;
    x.tag = tag;
    x.val = e;
    exp_q.push_back(x);
    @(negedge clk);
    y = exp_q.pop_front();
    o = obs();
    checks++;
    assert (o === y.val) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", y.tag, o, y.val);
    end
    if (McDoneE === 1'b1) done_cyc.push_back(cycle);
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; MultiCycleE = 0;
  endtask

  localparam logic [10:0] Zero   = 11'b0;
  localparam logic [10:0] RstOut = 11'b0000_000_110_0;

  initial begin
    int d;
    logic [10:0] mc_stall_v;
    logic [10:0] mc_done_v;
    mc_stall_v = ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0);
    mc_done_v  = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Reset overrides forwarding that would otherwise match.
    Rs1E = 5; RdM = 5; RegWriteM = 1;
    step("reset_a", RstOut);
    step("reset_b", RstOut);
    reset = 1'b0;
    clear_inputs();
    step("idle", Zero);

    // Forwarding
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    step("fwd_mem_prio", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    Rs1E = 0;
    step("fwd_x0", Zero);
    Rs1E = 3; RdM = 3; Rs2E = 9; RdW = 9;
    step("fwd_a_mem_b_wb", ev(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    Rs1E = 4; RdM = 4; RegWriteM = 0; RdW = 4; Rs2E = 4;
    step("fwd_wb_only", ev(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    RegWriteW = 0;
    step("fwd_no_we", Zero);
    clear_inputs();

    // Load-use
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    step("lw_rs2", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0));
    RdE = 0; Rs2D = 0;
    step("lw_rd0", Zero);
    RdE = 7; Rs1D = 7;
    step("lw_rs1", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0));
    Rs1D = 3; Rs2D = 4;
    step("lw_nomatch", Zero);
    ResultSrcE0 = 0; Rs1D = 7;
    step("lw_notload", Zero);
    clear_inputs();

    // Branch
    PCSrcE = 1;
    step("branch", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0));
    clear_inputs();

    // Single multi-cycle op, with a load-use hazard during the hold
    MultiCycleE = 1;
    step("mc1_c1", mc_stall_v);
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    step("mc1_c2_lw", mc_stall_v);
    ResultSrcE0 = 0; RdE = 0; Rs2D = 0;
    step("mc1_c3", mc_stall_v);
    step("mc1_c4_done", mc_done_v);
    MultiCycleE = 0;
    step("mc1_c5_idle", Zero);
    step("mc1_c6_idle", Zero);

    // Back-to-back ops
    done_cyc.delete();
    MultiCycleE = 1;
    for (int k = 0; k < 2; k++) begin
      step("b2b_s1", mc_stall_v);
      step("b2b_s2", mc_stall_v);
      step("b2b_s3", mc_stall_v);
      step("b2b_done", mc_done_v);
    end
    MultiCycleE = 0;
    step("b2b_idle", Zero);
    checks++;
    d = (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1;
    assert (d == 4) else begin
      failures++;
      $error("FAIL b2b_spacing observed=%0d expected=4", d);
    end

    // Reset during the second BUSY cycle
    MultiCycleE = 1;
    step("rst_mc_c1", mc_stall_v);
    step("rst_mc_c2", mc_stall_v);
    reset = 1;
    step("rst_mc_in_reset", RstOut);
    reset = 0;
    MultiCycleE = 0;
    step("rst_mc_after1", Zero);
    step("rst_mc_after2", Zero);
    step("rst_mc_after3", Zero);
    // A fresh op must take the full latency again.
    MultiCycleE = 1;
    step("rst_mc_new_c1", mc_stall_v);
    step("rst_mc_new_c2", mc_stall_v);
    step("rst_mc_new_c3", mc_stall_v);
    step("rst_mc_new_done", mc_done_v);
    MultiCycleE = 0;
    step("rst_mc_new_idle", Zero);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
